// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types for the pipelined ALU stage and its helpers.
//   op_t      : operation select (ADD, SUB, ADC, SBC, LOGIC, SHIFT, MUL)
//   sh_mode_t : roller mode (SHL, SHR, SAR, ROR)
//   flags_t   : {c, v, z, n} status flags, packed so it maps onto a 4-bit port
//   state_t   : sequencer state, encoded as plain logic constants
// ---------------------------------------------------------------------------
package alu_pkg;

   typedef enum logic [2:0] {
      ADD   = 3'd0,
      SUB   = 3'd1,
      ADC   = 3'd2,
      SBC   = 3'd3,
      LOGIC = 3'd4,
      SHIFT = 3'd5,
      MUL   = 3'd6
   } op_t;

   typedef enum logic [1:0] {
      SHL = 2'd0,
      SHR = 2'd1,
      SAR = 2'd2,
      ROR = 2'd3
   } sh_mode_t;

   typedef struct packed {
      logic c;
      logic v;
      logic z;
      logic n;
   } flags_t;

   // State encoding kept as bare constants so older tools and netlists
   // that expect a raw state vector keep working.
   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE = 1'b0;
   localparam state_t ST_MUL  = 1'b1;

   // Replace Z and N, keep C and V: used by every non-arithmetic result.
   function automatic flags_t zn_update(input flags_t f, input logic z, input logic n);
      flags_t r;
      r   = f;
      r.z = z;
      r.n = n;
      return r;
   endfunction

endpackage

// File: rtl/barrel_roller.sv
// ---------------------------------------------------------------------------
// barrel_roller
// Combinational log-stage shifter/rotator. Stage k moves the word by 2^k
// positions when off[k] is set, so any amount 0..WIDTH-1 is reached in
// $clog2(WIDTH) stages.
//   x       in  WIDTH          data to move
//   off     in  $clog2(WIDTH)  amount
//   sh_mode in  2              SHL, SHR, SAR (MSB replicated), ROR
//   y       out WIDTH          moved data
// ---------------------------------------------------------------------------
module barrel_roller
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0]         x,
   input  logic [$clog2(WIDTH)-1:0] off,
   input  sh_mode_t                 sh_mode,
   output logic [WIDTH-1:0]         y
);

   localparam int LG = $clog2(WIDTH);

   logic [WIDTH-1:0] stage_s;

   // One fixed-distance move; the distance is a constant once the stage
   // loop is unrolled, so each stage is just wiring plus a mux.
   function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v,
                                             input int               k,
                                             input sh_mode_t         m);
      logic [WIDTH-1:0] r;
      int               s;
      s = 1 << k;
      case (m)
         SHL:     r = v << s;
         SHR:     r = v >> s;
         SAR:     r = $unsigned($signed(v) >>> s);
         ROR:     r = (v >> s) | (v << (WIDTH - s));
         default: r = v;
      endcase
      return r;
   endfunction

   // Cascade of log2(WIDTH) conditional stages.
   always_comb begin
      stage_s = x;
      for (int k = 0; k < LG; k++) begin
         if (off[k]) begin
            stage_s = step(stage_s, k, sh_mode);
         end else begin
            stage_s = stage_s;
         end
      end
      y = stage_s;
   end

endmodule

// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe
// Handshaked ALU stage between register-file read and write-back. Results
// land in an output register with valid/ready flow control; a persistent
// flags register feeds carry-chained ADC/SBC; MUL runs an iterative
// shift-add over WIDTH cycles.
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready operation handshake (in_ready is combinational)
//   op, a, b          operation and operands
//   sh_off, sh_mode   roller controls (SHIFT result, LOGIC b-operand)
//   truth_table       LOGIC function, indexed by {a[i], rolled_b[i]}
//   i_dst / o_dst     destination tag in / out
//   out_valid/out_ready result handshake
//   out, flags        registered result and {C, V, Z, N}
// ---------------------------------------------------------------------------
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DST_W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  op_t                      op,
   input  logic [WIDTH-1:0]         a,
   input  logic [WIDTH-1:0]         b,
   input  logic [$clog2(WIDTH)-1:0] sh_off,
   input  sh_mode_t                 sh_mode,
   input  logic [3:0]               truth_table,
   input  logic [DST_W-1:0]         i_dst,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out,
   output logic [DST_W-1:0]         o_dst,
   output flags_t                   flags
);

   localparam int                 CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]   CNT_ZERO = CNT_W'(0);
   localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
   localparam logic [DST_W-1:0]   ZERO_D   = {DST_W{1'b0}};

   // Registered state
   state_t             state_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [WIDTH-1:0]   mcand_r;
   logic [WIDTH-1:0]   mplier_r;
   logic [WIDTH-1:0]   acc_r;
   logic [DST_W-1:0]   mul_dst_r;
   logic [WIDTH-1:0]   out_r;
   logic [DST_W-1:0]   o_dst_r;
   flags_t             flags_r;
   logic               out_valid_r;

   // Combinational datapath
   logic               in_ready_s;
   logic               accept_s;
   logic               drain_s;
   logic [WIDTH-1:0]   rolled_b_s;
   logic               inv_b_s;
   logic               cin_s;
   logic [WIDTH-1:0]   b_op_s;
   logic [WIDTH:0]     sum_s;
   logic               ovf_s;
   logic [WIDTH-1:0]   logic_res_s;
   logic [WIDTH-1:0]   result_s;
   flags_t             nxt_flags_s;
   logic [WIDTH-1:0]   mul_add_s;
   logic [WIDTH-1:0]   mul_sum_s;

   // The roller serves both SHIFT (as the result) and LOGIC (as rolled_b).
   barrel_roller #(
      .WIDTH   (WIDTH)
   ) u_roller (
      .x       (b),
      .off     (sh_off),
      .sh_mode (sh_mode),
      .y       (rolled_b_s)
   );

   // Handshake: accept only from IDLE with an empty or draining output slot.
   always_comb begin
      in_ready_s = !rst && (state_r == ST_IDLE) && (!out_valid_r || out_ready);
      accept_s   = in_valid && in_ready_s;
      drain_s    = out_valid_r && out_ready;
   end

   // Adder operand select: SUB/SBC invert b; carry-in is 1 for SUB, C for ADC/SBC.
   always_comb begin
      inv_b_s = 1'b0;
      cin_s   = 1'b0;
      case (op)
         ADD:     begin inv_b_s = 1'b0; cin_s = 1'b0;      end
         SUB:     begin inv_b_s = 1'b1; cin_s = 1'b1;      end
         ADC:     begin inv_b_s = 1'b0; cin_s = flags_r.c; end
         SBC:     begin inv_b_s = 1'b1; cin_s = flags_r.c; end
         default: begin inv_b_s = 1'b0; cin_s = 1'b0;      end
      endcase
   end

   // Single WIDTH+1 adder; bit WIDTH is the carry-out (C=1 means no borrow).
   always_comb begin
      b_op_s = inv_b_s ? ~b : b;
      sum_s  = {1'b0, a} + {1'b0, b_op_s} + {{WIDTH{1'b0}}, cin_s};
      ovf_s  = (a[WIDTH-1] == b_op_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
   end

   // Per-bit LUT: each result bit picks a truth_table entry by {a[i], rolled_b[i]}.
   always_comb begin
      logic_res_s = ZERO_W;
      for (int i = 0; i < WIDTH; i++) begin
         logic_res_s[i] = truth_table[{a[i], rolled_b_s[i]}];
      end
   end

   // Single-cycle result and flag update; MUL is finished by the sequencer.
   always_comb begin
      result_s    = ZERO_W;
      nxt_flags_s = flags_r;
      case (op)
         ADD, SUB, ADC, SBC: begin
            result_s      = sum_s[WIDTH-1:0];
            nxt_flags_s.c = sum_s[WIDTH];
            nxt_flags_s.v = ovf_s;
            nxt_flags_s.z = (sum_s[WIDTH-1:0] == ZERO_W);
            nxt_flags_s.n = sum_s[WIDTH-1];
         end
         LOGIC: begin
            result_s    = logic_res_s;
            nxt_flags_s = zn_update(flags_r, logic_res_s == ZERO_W, logic_res_s[WIDTH-1]);
         end
         SHIFT: begin
            result_s    = rolled_b_s;
            nxt_flags_s = zn_update(flags_r, rolled_b_s == ZERO_W, rolled_b_s[WIDTH-1]);
         end
         default: begin
            result_s    = ZERO_W;
            nxt_flags_s = flags_r;
         end
      endcase
   end

   // Shift-add step: mplier_r already holds b << cnt, so only a bit test is needed.
   always_comb begin
      if (mcand_r[cnt_r]) begin
         mul_add_s = mplier_r;
      end else begin
         mul_add_s = ZERO_W;
      end
      mul_sum_s = acc_r + mul_add_s;
   end

   // Sequencer, output register and flags register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         cnt_r       <= CNT_ZERO;
         mcand_r     <= ZERO_W;
         mplier_r    <= ZERO_W;
         acc_r       <= ZERO_W;
         mul_dst_r   <= ZERO_D;
         out_r       <= ZERO_W;
         o_dst_r     <= ZERO_D;
         flags_r     <= 4'b0000;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  if (op == MUL) begin
                     // Any old result drains on this edge, so the slot is
                     // empty for the whole multiply.
                     mcand_r     <= a;
                     mplier_r    <= b;
                     mul_dst_r   <= i_dst;
                     acc_r       <= ZERO_W;
                     cnt_r       <= CNT_ZERO;
                     state_r     <= ST_MUL;
                     out_valid_r <= 1'b0;
                  end else begin
                     out_r       <= result_s;
                     o_dst_r     <= i_dst;
                     flags_r     <= nxt_flags_s;
                     out_valid_r <= 1'b1;
                  end
               end else if (drain_s) begin
                  out_valid_r <= 1'b0;
               end else begin
                  out_valid_r <= out_valid_r;
               end
            end
            ST_MUL: begin
               acc_r    <= mul_sum_s;
               mplier_r <= mplier_r << 1;
               if (cnt_r == CNT_LAST) begin
                  // The slot was empty at accept, so load regardless of out_ready.
                  out_r       <= mul_sum_s;
                  o_dst_r     <= mul_dst_r;
                  flags_r     <= zn_update(flags_r, mul_sum_s == ZERO_W, mul_sum_s[WIDTH-1]);
                  out_valid_r <= 1'b1;
                  state_r     <= ST_IDLE;
                  cnt_r       <= CNT_ZERO;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               cnt_r       <= CNT_ZERO;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_r;
   assign out       = out_r;
   assign o_dst     = o_dst_r;
   assign flags     = flags_r;

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
   import alu_pkg::*;

   localparam int WIDTH = 16;
   localparam int DST_W = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   op_t         op = ADD;
   logic [15:0] a = 16'h0000;
   logic [15:0] b = 16'h0000;
   logic [3:0]  sh_off = 4'd0;
   sh_mode_t    sh_mode = SHL;
   logic [3:0]  truth_table = 4'h0;
   logic [3:0]  i_dst = 4'h0;
   logic        in_ready;
   logic        out_valid;
   logic [15:0] out;
   logic [3:0]  o_dst;
   flags_t      flags;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_pipe #(.WIDTH(WIDTH), .DST_W(DST_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .sh_off(sh_off), .sh_mode(sh_mode),
      .truth_table(truth_table), .i_dst(i_dst), .out_valid(out_valid),
      .out_ready(out_ready), .out(out), .o_dst(o_dst), .flags(flags)
   );

   typedef struct {
      op_t         op;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  off;
      sh_mode_t    mode;
      logic [3:0]  tt;
      logic [15:0] exp_out;
      logic [3:0]  exp_flags;
   } vec_t;

   typedef struct {
      logic [15:0] res;
      logic [3:0]  fl;
      logic [3:0]  dst;
   } exp_t;

   vec_t vecs [16];
   exp_t sbq [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference roller: plain integer shifts on a sign-extended copy.
   function automatic logic [15:0] roll_ref(input logic [15:0] x, input int s, input sh_mode_t m);
      longint v;
      longint sv;
      longint r;
      v  = longint'(x);
      sv = x[15] ? v - 65536 : v;
      case (m)
         SHL:     r = v << s;
         SHR:     r = v >> s;
         SAR:     r = sv >>> s;
         ROR:     r = (v >> s) | (v << (16 - s));
         default: r = 0;
      endcase
      return r[15:0];
   endfunction

   // Reference ALU: true unsigned/signed sums decide C and V.
   function automatic void ref_model(input op_t o, input logic [15:0] ai, input logic [15:0] bi,
                                     input int s, input sh_mode_t m, input logic [3:0] tt,
                                     input logic [3:0] fin, output logic [15:0] res,
                                     output logic [3:0] fout);
      longint ua, ub, sa, sb, cin, u, t;
      logic [15:0] rb;
      logic c, v;
      ua  = longint'(ai);
      ub  = longint'(bi);
      sa  = ai[15] ? ua - 65536 : ua;
      sb  = bi[15] ? ub - 65536 : ub;
      cin = fin[3] ? 1 : 0;
      c   = fin[3];
      v   = fin[2];
      rb  = roll_ref(bi, s, m);
      u   = 0;
      t   = 0;
      case (o)
         ADD: begin u = ua + ub;               t = sa + sb;           end
         SUB: begin u = ua - ub + 65536;       t = sa - sb;           end
         ADC: begin u = ua + ub + cin;         t = sa + sb + cin;     end
         SBC: begin u = ua + (65535 - ub) + cin; t = sa - sb - 1 + cin; end
         LOGIC: begin
            for (int i = 0; i < 16; i++) begin
               if (tt[{ai[i], rb[i]}]) u = u | (longint'(1) << i);
            end
         end
         SHIFT: u = longint'(rb);
         MUL:   u = ua * ub;
         default: u = 0;
      endcase
      res = u[15:0];
      if (o == ADD || o == SUB || o == ADC || o == SBC) begin
         c = (u > 65535);
         v = (t > 32767) || (t < -32768);
      end
      fout = {c, v, (res == 16'h0000), res[15]};
   endfunction

   function automatic logic [15:0] pick_val();
      case ($urandom_range(0, 7))
         0: return 16'h0000;
         1: return 16'hFFFF;
         2: return 16'h8000;
         3: return 16'h7FFF;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      int          viol;
      logic [15:0] e_res;
      logic [3:0]  e_fl;
      logic [3:0]  mflags;
      exp_t        e;

      //            op     a         b         off  mode tt     out       {C,V,Z,N}
      vecs[0]  = '{ADD,   16'hFFFF, 16'h0001, 4'd0,  SHL, 4'h0,  16'h0000, 4'b1010};
      vecs[1]  = '{ADC,   16'h0000, 16'h0000, 4'd0,  SHL, 4'h0,  16'h0001, 4'b0000};
      vecs[2]  = '{SUB,   16'h8000, 16'h0001, 4'd0,  SHL, 4'h0,  16'h7FFF, 4'b1100};
      vecs[3]  = '{ADD,   16'h0000, 16'h0000, 4'd0,  SHL, 4'h0,  16'h0000, 4'b0010};
      vecs[4]  = '{SBC,   16'h0000, 16'h0000, 4'd0,  SHL, 4'h0,  16'hFFFF, 4'b0001};
      vecs[5]  = '{LOGIC, 16'h00FF, 16'h0F0F, 4'd4,  SHL, 4'h6,  16'hF00F, 4'b0001};
      vecs[6]  = '{SHIFT, 16'h0000, 16'h8000, 4'd4,  SAR, 4'h0,  16'hF800, 4'b0001};
      vecs[7]  = '{ADD,   16'h7FFF, 16'h0001, 4'd0,  SHL, 4'h0,  16'h8000, 4'b0101};
      vecs[8]  = '{SHIFT, 16'h0000, 16'h1234, 4'd4,  ROR, 4'h0,  16'h4123, 4'b0100};
      vecs[9]  = '{SHIFT, 16'h0000, 16'h8000, 4'd15, SHR, 4'h0,  16'h0001, 4'b0100};
      vecs[10] = '{SHIFT, 16'h0000, 16'hABCD, 4'd0,  SHL, 4'h0,  16'hABCD, 4'b0101};
      vecs[11] = '{LOGIC, 16'hF0F0, 16'hFF00, 4'd0,  SHL, 4'h8,  16'hF000, 4'b0101};
      vecs[12] = '{SUB,   16'h0000, 16'h0001, 4'd0,  SHL, 4'h0,  16'hFFFF, 4'b0001};
      vecs[13] = '{SUB,   16'h0005, 16'h0005, 4'd0,  SHL, 4'h0,  16'h0000, 4'b1010};
      vecs[14] = '{ADC,   16'h7FFF, 16'h0000, 4'd0,  SHL, 4'h0,  16'h8000, 4'b0101};
      vecs[15] = '{LOGIC, 16'h1234, 16'h5678, 4'd3,  ROR, 4'h0,  16'h0000, 4'b0110};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst in_ready", 32'(in_ready), 32'h0);
      check("rst out_valid", 32'(out_valid), 32'h0);
      check("rst out", 32'(out), 32'h0);
      check("rst o_dst", 32'(o_dst), 32'h0);
      check("rst flags", 32'(flags), 32'h0);
      rst = 1'b0;
      #1;
      check("post-rst in_ready", 32'(in_ready), 32'h1);

      // Directed table, one op per cycle with out_ready high
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
         sh_off = vecs[i].off; sh_mode = vecs[i].mode; truth_table = vecs[i].tt;
         i_dst = 4'(i);
         in_valid = 1'b1;
         #1;
         check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'h1);
         tick();
         check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'h1);
         check($sformatf("vec%0d out", i), 32'(out), 32'(vecs[i].exp_out));
         check($sformatf("vec%0d flags", i), 32'(flags), 32'(vecs[i].exp_flags));
         check($sformatf("vec%0d o_dst", i), 32'(o_dst), 32'(i));
      end

      // MUL latency: drain of the last vector and MUL accept share an edge
      op = MUL; a = 16'h0123; b = 16'h0010; i_dst = 4'hA; in_valid = 1'b1;
      #1;
      check("mul accept in_ready", 32'(in_ready), 32'h1);
      tick();
      in_valid = 1'b0;
      viol = 0;
      for (int k = 0; k < WIDTH; k++) begin
         if (out_valid !== 1'b0 || in_ready !== 1'b0) viol++;
         if (k < WIDTH - 1) tick();
      end
      check("mul busy window", 32'(viol), 32'h0);
      tick();
      check("mul out_valid", 32'(out_valid), 32'h1);
      check("mul out", 32'(out), 32'h1230);
      check("mul o_dst", 32'(o_dst), 32'hA);
      check("mul flags", 32'(flags), 32'h4);

      // Second MUL aborted by reset at cycle 8
      op = MUL; a = 16'hFFFF; b = 16'hFFFF; i_dst = 4'h3; in_valid = 1'b1;
      #1;
      tick();
      in_valid = 1'b0;
      check("mul drain+accept valid", 32'(out_valid), 32'h0);
      repeat (7) tick();
      rst = 1'b1;
      #1;
      check("rst-high in_ready", 32'(in_ready), 32'h0);
      tick();
      rst = 1'b0;
      #1;
      check("abort flags", 32'(flags), 32'h0);
      check("abort in_ready", 32'(in_ready), 32'h1);
      viol = 0;
      for (int k = 0; k < 20; k++) begin
         if (out_valid !== 1'b0) viol++;
         tick();
      end
      check("abort no result", 32'(viol), 32'h0);

      // Backpressure: hold out_ready low with a second op waiting
      op = ADD; a = 16'h0001; b = 16'h0002; i_dst = 4'h5; in_valid = 1'b1; out_ready = 1'b0;
      #1;
      check("bp first in_ready", 32'(in_ready), 32'h1);
      tick();
      a = 16'h000A; b = 16'h0014; i_dst = 4'h6;
      for (int k = 0; k < 5; k++) begin
         check("bp out_valid", 32'(out_valid), 32'h1);
         check("bp out", 32'(out), 32'h0003);
         check("bp o_dst", 32'(o_dst), 32'h5);
         check("bp in_ready", 32'(in_ready), 32'h0);
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("bp release in_ready", 32'(in_ready), 32'h1);
      tick();
      in_valid = 1'b0;
      check("bp swap out_valid", 32'(out_valid), 32'h1);
      check("bp swap out", 32'(out), 32'h001E);
      check("bp swap o_dst", 32'(o_dst), 32'h6);
      check("bp swap flags", 32'(flags), 32'h0);
      tick();
      check("bp drained", 32'(out_valid), 32'h0);

      // Randomized traffic against the reference model
      mflags = 4'b0000;
      for (int cyc = 0; cyc < 600; cyc++) begin
         in_valid    = ($urandom_range(0, 9) < 7);
         op          = op_t'(3'($urandom_range(0, 6)));
         a           = pick_val();
         b           = pick_val();
         sh_off      = 4'($urandom_range(0, 15));
         sh_mode     = sh_mode_t'(2'($urandom_range(0, 3)));
         truth_table = 4'($urandom);
         i_dst       = 4'($urandom);
         out_ready   = ($urandom_range(0, 3) != 0);
         #1;
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               check("rand spurious result", 32'h1, 32'h0);
            end else begin
               e = sbq.pop_front();
               check("rand out", 32'(out), 32'(e.res));
               check("rand o_dst", 32'(o_dst), 32'(e.dst));
               check("rand flags", 32'(flags), 32'(e.fl));
            end
         end
         if (in_valid && in_ready) begin
            ref_model(op, a, b, int'(sh_off), sh_mode, truth_table, mflags, e_res, e_fl);
            mflags = e_fl;
            sbq.push_back('{e_res, e_fl, i_dst});
         end
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 40 && sbq.size() > 0; k++) begin
         #1;
         if (out_valid) begin
            e = sbq.pop_front();
            check("drain out", 32'(out), 32'(e.res));
            check("drain o_dst", 32'(o_dst), 32'(e.dst));
            check("drain flags", 32'(flags), 32'(e.fl));
         end
         tick();
      end
      check("rand pending results", 32'(sbq.size()), 32'h0);
      tick();
      check("rand idle out_valid", 32'(out_valid), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked ALU stage; successor to the combinational 16-bit ALU. Adds a registered output with valid/ready flow control, a persistent flags register (C, V, Z, N) enabling carry-chained ADC/SBC, and an iterative shift-add multiplier. It sits between register-file read and write-back. It passes a destination tag through with each result and has no tri-state output.

## Interface
- WIDTH, 16, datapath width (≥4, power of two)
- DST_W, 4, destination tag width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operation presented
- in_ready  out  1  stage can accept
- op  in  3  alu_pkg::op_t: ADD, SUB, ADC, SBC, LOGIC, SHIFT, MUL
- a, b  in  WIDTH  operands
- sh_off  in  $clog2(WIDTH)  roller amount
- sh_mode  in  2  alu_pkg::sh_mode_t: SHL, SHR, SAR, ROR
- truth_table  in  4  LOGIC function, bit index {a[i], rolled_b[i]}
- i_dst  in  DST_W  destination tag
- out_valid  out  1  result held in output register
- out_ready  in  1  consumer accepts result
- out  out  WIDTH  result
- o_dst  out  DST_W  tag of result
- flags  out  4  {C, V, Z, N}, registered

## Operation
- Accept when in_valid && in_ready. in_ready = !rst && state==IDLE && (!out_valid || out_ready). This is combinational and has no dependency on in_valid.
- ADD: a+b. SUB: a+~b+1. ADC: a+b+C. SBC: a+~b+C. C is the carry-out, so C=1 means no borrow. V is the signed overflow of the same sum. Z and N are taken from the result.
- LOGIC: out[i] = truth_table[{a[i], rolled_b[i]}], where rolled_b is b passed through the roller with sh_off/sh_mode. Updates Z, N. C and V are unchanged.
- SHIFT: out = rolled_b. SAR replicates the MSB. ROR rotates right. sh_off=0 gives b. Updates Z, N. C and V are unchanged.
- MUL: low WIDTH bits of a*b, unsigned. It is computed by shift-add, one multiplier bit per cycle. Updates Z, N. C and V are unchanged.
- FSM states:
  - IDLE: on accept of a non-MUL op, load out, o_dst and flags; set out_valid. On accept of MUL, latch operands and tag, clear the accumulator, set cnt=0, go to MUL.
  - MUL: each cycle, if mcand bit cnt is set, add the shifted multiplier to the accumulator; cnt++. At cnt==WIDTH-1, write the final sum to out and flags, set out_valid, go to IDLE. This happens even if out_ready is low, because the output register was empty at accept.
- out_valid clears on out_valid && out_ready unless a new result loads on the same edge.
- The flags register updates only when a result loads into out. An ADC accepted on the cycle after an ADD sees the ADD's carry.

## Timing
- Reset values: out_valid=0, out=0, o_dst=0, flags=0, state=IDLE, cnt=0. in_ready is 0 while rst is high and 1 on the first cycle after.
- Non-MUL latency: accepted at edge N, out_valid high after edge N. Throughput is 1/cycle when out_ready is held high.
- MUL latency: accepted at edge N, out_valid high after edge N+WIDTH. in_ready is 0 from after edge N until the result loads.
- Backpressure: while out_valid && !out_ready, out, o_dst and flags hold stable and in_ready=0.
- Simultaneous drain and accept (out_valid && out_ready && accept): the new non-MUL result loads and out_valid stays 1. For a MUL accept, out_valid drops to 0.
- Reset mid-MUL aborts the operation, emits no result, and clears flags.
- All arithmetic wraps modulo 2^WIDTH. sh_off ranges 0..WIDTH-1.

## Structure
- Package alu_pkg: op_t, sh_mode_t, flags_t struct {c, v, z, n}, state_t {IDLE, MUL}.
- Sub-module barrel_roller #(WIDTH): combinational log-stage shifter/rotator taking x, off, sh_mode and producing y. It is also reusable by other cores.
- The adder is inline: one WIDTH+1-bit sum with an optional ~b and a carry-in mux.

## Test plan
- ADD a=0xFFFF, b=0x0001 -> out=0x0000, flags C=1 V=0 Z=1 N=0. out_valid is high one cycle after accept.
- ADD 0xFFFF+0x0001, then ADC a=0x0000 b=0x0000 on the next cycle -> out=0x0001, C=0, Z=0.
- SUB a=0x8000, b=0x0001 -> out=0x7FFF, C=1, V=1, N=0. SBC with a=0x0000, b=0x0000, C=0 -> 0xFFFF, C=0, N=1.
- LOGIC tt=4'b0110, a=0x00FF, b=0x0F0F, SHL by 4 -> out=0xF00F. SHIFT SAR by 4 of b=0x8000 -> 0xF800.
- MUL a=0x0123, b=0x0010 -> out=0x1230 exactly 16 cycles after accept, with in_ready=0 throughout. Asserting rst at cycle 8 of a second MUL -> no out_valid, flags=0.
- Hold out_ready=0 for 5 cycles with in_valid=1 -> out and o_dst stable, no second accept. Raising out_ready -> drain and accept occur on the same edge, and out_valid stays high.
